// File: rtl/demux_18_16bit_buffered_pkg.sv
`default_nettype none
// ============================================================================
// Module      : demux_pkg
// Description : Shared constants, mode encoding and lane-select helper for
//               the buffered 1-to-8 demultiplexer.
// Revision    : 1.0 - initial release
// ============================================================================
package demux_pkg;

    localparam int LANES         = 8;
    localparam int SEL_W         = 3;
    localparam int DEFAULT_WIDTH = 16;

    localparam logic [SEL_W-1:0] LAST_LANE = 3'd7;

    typedef enum logic {
        MODE_ADDR = 1'b0,
        MODE_AUTO = 1'b1
    } mode_e;

    function automatic logic [LANES-1:0] lane_onehot(input logic [SEL_W-1:0] sel);
        logic [LANES-1:0] v;
        v      = '0;
        v[sel] = 1'b1;
        return v;
    endfunction

endpackage : demux_pkg
`default_nettype wire

// File: rtl/demux_18_16bit_buffered_lane_reg.sv
`default_nettype none
// ============================================================================
// Module      : demux_lane_reg
// Description : One output lane: data register plus held-word flag with
//               consumer acknowledge. Data is kept after the flag clears.
// Revision    : 1.0 - initial release
// ============================================================================
module demux_lane_reg
    import demux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_ack,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid
);

    logic [WIDTH-1:0] r_data;
    logic             r_valid;

    // A load in the same cycle as an ack wins: the lane stays full with new data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_data  <= i_data;
            r_valid <= 1'b1;
        end else if (i_ack && r_valid) begin
            r_valid <= 1'b0;
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;

endmodule : demux_lane_reg
`default_nettype wire

// File: rtl/demux_18_16bit_buffered.sv
`default_nettype none
// ============================================================================
// Module      : demux_18_16bit_buffered
// Description : Buffered 1-to-8 demultiplexer with per-lane valid/ack and an
//               optional round-robin lane pointer (macro DEMUX_18_AUTO_SEQ_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module demux_18_16bit_buffered
    import demux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WIDTH-1:0]       a,
    input  logic                   s2,
    input  logic                   s1,
    input  logic                   s0,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   auto_mode,
    output logic [LANES*WIDTH-1:0] y,
    output logic [LANES-1:0]       out_valid,
    input  logic [LANES-1:0]       out_ack,
    output logic [SEL_W-1:0]       ptr,
    output logic                   frame_done
);

    logic [SEL_W-1:0] w_sel;
    logic [SEL_W-1:0] w_target;
    logic [LANES-1:0] w_lane_valid;
    logic [LANES-1:0] w_load;
    logic             w_accept;

    assign w_sel = {s2, s1, s0};

`ifdef DEMUX_18_AUTO_SEQ_EN
    mode_e            w_mode;
    logic [SEL_W-1:0] r_ptr;
    logic             r_frame_done;

    assign w_mode   = auto_mode ? MODE_AUTO : MODE_ADDR;
    assign w_target = (w_mode == MODE_AUTO) ? r_ptr : w_sel;

    // Pointer is held at 0 in addressed mode so auto mode always starts at lane 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr        <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= (w_mode == MODE_AUTO) && w_accept && (r_ptr == LAST_LANE);
            if (w_mode == MODE_ADDR) begin
                r_ptr <= '0;
            end else if (w_accept) begin
                r_ptr <= r_ptr + 3'd1;
            end
        end
    end

    assign ptr        = r_ptr;
    assign frame_done = r_frame_done;
`else
    logic w_unused_auto_mode;

    assign w_unused_auto_mode = auto_mode;
    assign w_target           = w_sel;
    assign ptr                = '0;
    assign frame_done         = 1'b0;
`endif

    // A full lane can still take a word when its consumer acks this cycle.
    assign in_ready = !w_lane_valid[w_target] | out_ack[w_target];
    assign w_accept = in_valid & in_ready;
    assign w_load   = w_accept ? lane_onehot(w_target) : '0;

    generate
        for (genvar i = 0; i < LANES; i++) begin : g_lane
            demux_lane_reg #(
                .WIDTH (WIDTH)
            ) u_lane (
                .clk     (clk),
                .rst_n   (rst_n),
                .i_load  (w_load[i]),
                .i_data  (a),
                .i_ack   (out_ack[i]),
                .o_data  (y[i*WIDTH +: WIDTH]),
                .o_valid (w_lane_valid[i])
            );
        end
    endgenerate

    assign out_valid = w_lane_valid;

endmodule : demux_18_16bit_buffered
`default_nettype wire

// File: tb/tb_demux_18_16bit_buffered.sv
`default_nettype none
// ============================================================================
// Module      : tb_demux_18_16bit_buffered
// Description : Directed self-checking bench for demux_18_16bit_buffered.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_demux_18_16bit_buffered;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [15:0]  a;
    logic         s2, s1, s0;
    logic         in_valid;
    logic         in_ready;
    logic         auto_mode;
    logic [127:0] y;
    logic [7:0]   out_valid;
    logic [7:0]   out_ack;
    logic [2:0]   ptr;
    logic         frame_done;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    demux_18_16bit_buffered #(.WIDTH(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .a          (a),
        .s2         (s2),
        .s1         (s1),
        .s0         (s0),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .auto_mode  (auto_mode),
        .y          (y),
        .out_valid  (out_valid),
        .out_ack    (out_ack),
        .ptr        (ptr),
        .frame_done (frame_done)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_sel(input logic [2:0] sel);
        {s2, s1, s0} = sel;
        #1;
    endtask

    logic [127:0] exp_y;

    initial begin
        rst_n = 1'b0; a = '0; {s2, s1, s0} = 3'b000; in_valid = 1'b0;
        auto_mode = 1'b0; out_ack = '0;
        step(); step();
        chk("rst_y", y, 128'h0);
        chk("rst_out_valid", out_valid, 8'h00);
        chk("rst_ptr", ptr, 3'd0);
        chk("rst_frame_done", frame_done, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        rst_n = 1'b1;
        step();

        // addressed write to lane 5
        a = 16'hBEEF; set_sel(3'b101); in_valid = 1'b1; #1;
        chk("wr5_in_ready", in_ready, 1'b1);
        step();
        in_valid = 1'b0;
        chk("wr5_lane5", y[5*16 +: 16], 16'hBEEF);
        chk("wr5_out_valid", out_valid, 8'b0010_0000);
        set_sel(3'b000);
        chk("wr5_ready_other", in_ready, 1'b1);
        set_sel(3'b101);
        chk("wr5_ready_full", in_ready, 1'b0);

        // ack lane 5: flag clears, data kept
        out_ack = 8'h20; step(); out_ack = 8'h00;
        chk("ack5_out_valid", out_valid, 8'h00);
        chk("ack5_data_kept", y[5*16 +: 16], 16'hBEEF);

        // ack on an empty lane is ignored
        out_ack = 8'h01; step(); out_ack = 8'h00;
        chk("ack_empty", out_valid, 8'h00);

        // backpressure on lane 2
        a = 16'h1111; set_sel(3'd2); in_valid = 1'b1;
        step();
        chk("bp_first_valid", out_valid, 8'h04);
        a = 16'h2222; #1;
        chk("bp_ready_low", in_ready, 1'b0);
        step();
        chk("bp_data_held", y[2*16 +: 16], 16'h1111);
        chk("bp_valid_held", out_valid, 8'h04);
        out_ack = 8'h04; #1;
        chk("bp_ready_ack", in_ready, 1'b1);
        step();
        in_valid = 1'b0; out_ack = 8'h00;
        chk("bp_new_data", y[2*16 +: 16], 16'h2222);
        chk("bp_valid_stays", out_valid, 8'h04);

        // drain lane 2, fill all lanes, multi-ack
        out_ack = 8'h04; step(); out_ack = 8'h00;
        exp_y = '0;
        for (int i = 0; i < 8; i++) begin
            a = 16'hC000 + 16'(i); set_sel(3'(i)); in_valid = 1'b1;
            exp_y[i*16 +: 16] = 16'hC000 + 16'(i);
            step();
        end
        in_valid = 1'b0;
        chk("fill_out_valid", out_valid, 8'hFF);
        chk("fill_y", y, exp_y);
        out_ack = 8'h81; step(); out_ack = 8'h00;
        chk("mack_out_valid", out_valid, 8'h7E);
        chk("mack_y", y, exp_y);
        out_ack = 8'hFF; step(); out_ack = 8'h00;
        chk("drain_all", out_valid, 8'h00);

`ifdef DEMUX_18_AUTO_SEQ_EN
        // round-robin frame of 8 words
        auto_mode = 1'b1; set_sel(3'd6);
        exp_y = y;
        for (int i = 0; i < 8; i++) begin
            a = 16'(i); in_valid = 1'b1;
            exp_y[i*16 +: 16] = 16'(i);
            step();
            chk("auto_ptr", ptr, 3'(i + 1));
            chk("auto_frame_done", frame_done, (i == 7) ? 1'b1 : 1'b0);
        end
        in_valid = 1'b0;
        chk("auto_y", y, exp_y);
        step();
        chk("auto_frame_done_drop", frame_done, 1'b0);

        // stall on full lane 3 with ptr at 3
        out_ack = 8'h07; step(); out_ack = 8'h00;
        for (int i = 0; i < 3; i++) begin
            a = 16'h0020 + 16'(i); in_valid = 1'b1; step();
        end
        chk("stall_ptr3", ptr, 3'd3);
        a = 16'h0023; #1;
        chk("stall_ready_low", in_ready, 1'b0);
        step();
        chk("stall_ptr_held", ptr, 3'd3);
        chk("stall_lane3_held", y[3*16 +: 16], 16'h0003);
        out_ack = 8'h08; #1;
        chk("stall_ready_ack", in_ready, 1'b1);
        step();
        in_valid = 1'b0; out_ack = 8'h00;
        chk("stall_ptr_adv", ptr, 3'd4);
        chk("stall_lane3_new", y[3*16 +: 16], 16'h0023);

        // mid-frame setup: ptr=4, out_valid=0F
        out_ack = 8'hFF; auto_mode = 1'b0; step(); out_ack = 8'h00;
        chk("addr_clears_ptr", ptr, 3'd0);
        auto_mode = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a = 16'h0040 + 16'(i); in_valid = 1'b1; step();
        end
        chk("mid_ptr", ptr, 3'd4);
`else
        // auto_mode ignored: behaves as addressed
        auto_mode = 1'b1; a = 16'h1234; set_sel(3'd3); in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("noauto_lane3", y[3*16 +: 16], 16'h1234);
        chk("noauto_valid", out_valid, 8'h08);
        chk("noauto_ptr", ptr, 3'd0);
        chk("noauto_frame_done", frame_done, 1'b0);
        out_ack = 8'hFF; step(); out_ack = 8'h00;
        for (int i = 0; i < 4; i++) begin
            a = 16'h0040 + 16'(i); set_sel(3'(i)); in_valid = 1'b1; step();
        end
`endif
        chk("mid_out_valid", out_valid, 8'h0F);

        // asynchronous reset with a write pending
        a = 16'hDEAD; set_sel(3'd6);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 8'h00);
        chk("arst_y", y, 128'h0);
        chk("arst_ptr", ptr, 3'd0);
        chk("arst_frame_done", frame_done, 1'b0);
        step();
        chk("arst_hold_y", y, 128'h0);
        in_valid = 1'b0; auto_mode = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("arst_in_ready", in_ready, 1'b1);
        step();
        chk("arst_no_late_accept", out_valid, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_demux_18_16bit_buffered
`default_nettype wire
